// File: rtl/cpu_term_pkg.sv
// cpu_term_pkg: shared types and helpers for the CPU bus termination sequencer.
//   - state_t : sequencer states (S_RETRY only when CPU_TERM_RETRY_EN is defined)
//   - ERR_*   : completion status codes reported on err
//   - SIZ_*   : 68030 SIZ encoding of bytes remaining in the longword
//   - port_width/term_bytes/lane_mask/siz_enc : termination decode helpers
package cpu_term_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_STRB, S_WAIT, S_TERM, S_DONE
`ifdef CPU_TERM_RETRY_EN
    , S_RETRY
`endif
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_BERR = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_ZLEN = 2'b11;

  localparam logic [1:0] SIZ_4 = 2'b00;
  localparam logic [1:0] SIZ_1 = 2'b01;
  localparam logic [1:0] SIZ_2 = 2'b10;
  localparam logic [1:0] SIZ_3 = 2'b11;

  // Port width in bytes from the termination inputs; 0 means no termination.
  // STERM_ always means a 32-bit port.
  function automatic logic [2:0] port_width(input logic sterm_n, input logic [1:0] dsack_n);
    logic [2:0] w;
    w = 3'd0;
    if (!sterm_n) w = 3'd4;
    else begin
      case (dsack_n)
        2'b00:   w = 3'd4;
        2'b01:   w = 3'd2;
        2'b10:   w = 3'd1;
        default: w = 3'd0;
      endcase
    end
    return w;
  endfunction

  // Bytes moved this cycle: min(port - off%port, 4 - off). For a 16-bit port
  // 2 - off[0] never exceeds 4 - off, so the min collapses per width.
  function automatic logic [2:0] term_bytes(input logic [2:0] port, input logic [1:0] off);
    logic [2:0] b;
    case (port)
      3'd4:    b = 3'd4 - {1'b0, off};
      3'd2:    b = off[0] ? 3'd1 : 3'd2;
      default: b = 3'd1;
    endcase
    return b;
  endfunction

  // Lanes off .. off+bytes-1; bytes never runs past lane 3.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] bytes);
    logic [4:0] m;
    m = (5'd1 << bytes) - 5'd1;
    return m[3:0] << off;
  endfunction

  // Remaining bytes in the longword, (4 - off) mod 4 in SIZ encoding.
  function automatic logic [1:0] siz_enc(input logic [1:0] off);
    logic [1:0] s;
    case (off)
      2'd0:    s = SIZ_4;
      2'd1:    s = SIZ_3;
      2'd2:    s = SIZ_2;
      default: s = SIZ_1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpu_sync.sv
// cpu_sync: STAGES-deep flop synchroniser for active-low async bus inputs.
//   clk, rst_n : clock, async active-low reset (flops reset to all-ones = negated)
//   d          : asynchronous input vector
//   q          : synchronised output
module cpu_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '1;
    else begin
      pipe[0] <= d;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/cpu_term_seq.sv
// cpu_term_seq: sequences 68030-style bus transfers of len longwords for the
// DMA master, splitting each longword into port-sized cycles terminated by
// STERM_ (raw), DSACK_[1:0] or BERR_ (both synchronised), with a watchdog.
//   BCLK, CCRESET_        : clock, async active-low reset
//   start, rw, len        : transfer request (accepted only in IDLE)
//   tmo_limit             : watchdog limit in BCLK cycles, 0 = disabled
//   DSACK_, STERM_, BERR_ : bus terminations (active low)
//   AS_, DS_, RW_o        : bus strobes and direction
//   A_lo, SIZ             : byte offset and remaining-size encoding
//   lane_le               : per-byte latch/drive enable, pulses in TERM
//   busy, done, err       : status; err valid with done
// Optional: define CPU_TERM_RETRY_EN to add halt_ and BERR_+HALT retry (max 3).
// Outputs are decoded from registered state so an async reset releases the
// strobes in the same instant.
module cpu_term_seq
  import cpu_term_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 8
) (
  input  logic             BCLK,
  input  logic             CCRESET_,
  input  logic             start,
  input  logic             rw,
  input  logic [LEN_W-1:0] len,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic [1:0]       DSACK_,
  input  logic             STERM_,
  input  logic             BERR_,
`ifdef CPU_TERM_RETRY_EN
  input  logic             halt_,
`endif
  output logic             AS_,
  output logic             DS_,
  output logic             RW_o,
  output logic [1:0]       A_lo,
  output logic [1:0]       SIZ,
  output logic [3:0]       lane_le,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  state_t           state, nstate;
  logic             rw_q, rw_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [1:0]       off, off_n;
  logic [2:0]       port_q, port_n;
  logic [TMO_W-1:0] wdog, wdog_n;
  logic [1:0]       err_q, err_n;
  logic [1:0]       dsack_s;
  logic             berr_s;
  logic [2:0]       pw, bytes, off_sum;

  cpu_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_dsack (
    .clk(BCLK), .rst_n(CCRESET_), .d(DSACK_), .q(dsack_s));
  cpu_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_berr (
    .clk(BCLK), .rst_n(CCRESET_), .d(BERR_), .q(berr_s));

`ifdef CPU_TERM_RETRY_EN
  logic       halt_s;
  logic [1:0] retry_cnt, retry_n;
  cpu_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_halt (
    .clk(BCLK), .rst_n(CCRESET_), .d(halt_), .q(halt_s));
`endif

  assign pw      = port_width(STERM_, dsack_s);
  assign bytes   = term_bytes(port_q, off);
  assign off_sum = {1'b0, off} + bytes;

  always_ff @(posedge BCLK or negedge CCRESET_) begin
    if (!CCRESET_) begin
      state  <= S_IDLE;
      rw_q   <= 1'b1;
      rem    <= '0;
      off    <= '0;
      port_q <= '0;
      wdog   <= '0;
      err_q  <= ERR_OK;
`ifdef CPU_TERM_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      state  <= nstate;
      rw_q   <= rw_n;
      rem    <= rem_n;
      off    <= off_n;
      port_q <= port_n;
      wdog   <= wdog_n;
      err_q  <= err_n;
`ifdef CPU_TERM_RETRY_EN
      retry_cnt <= retry_n;
`endif
    end
  end

  always_comb begin
    nstate = state;
    rw_n   = rw_q;
    rem_n  = rem;
    off_n  = off;
    port_n = port_q;
    wdog_n = wdog;
    err_n  = err_q;
`ifdef CPU_TERM_RETRY_EN
    retry_n = retry_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            err_n  = ERR_ZLEN;
            nstate = S_DONE;
          end else begin
            rw_n   = rw;
            rem_n  = len;
            off_n  = '0;
            wdog_n = '0;
            nstate = S_ADDR;
          end
        end
      end
      S_ADDR: nstate = S_STRB;
      S_STRB: nstate = S_WAIT;
      S_WAIT: begin
        // BERR_ > STERM_ > DSACK_; any termination beats the watchdog.
        if (!berr_s) begin
`ifdef CPU_TERM_RETRY_EN
          if (!halt_s && retry_cnt != 2'd3) begin
            retry_n = retry_cnt + 2'd1;
            nstate  = S_RETRY;
          end else begin
            err_n  = ERR_BERR;
            nstate = S_DONE;
          end
`else
          err_n  = ERR_BERR;
          nstate = S_DONE;
`endif
        end else if (pw != 3'd0) begin
          port_n = pw;
          nstate = S_TERM;
        end else begin
          wdog_n = wdog + 1'b1;
          if (tmo_limit != '0 && wdog_n == tmo_limit) begin
            err_n  = ERR_TMO;
            nstate = S_DONE;
          end
        end
      end
      S_TERM: begin
        wdog_n = '0;
`ifdef CPU_TERM_RETRY_EN
        retry_n = '0;
`endif
        off_n = off_sum[1:0];
        // off_sum[2] means the longword is complete; rem is nonzero here.
        if (off_sum[2]) rem_n = rem - 1'b1;
        if (rem_n != '0 || off_n != '0) nstate = S_ADDR;
        else begin
          err_n  = ERR_OK;
          nstate = S_DONE;
        end
      end
      S_DONE: begin
        off_n  = '0;
        wdog_n = '0;
        nstate = S_IDLE;
      end
`ifdef CPU_TERM_RETRY_EN
      S_RETRY: begin
        // Re-run the same cycle (off/rem untouched) once BERR_ and HALT drop.
        wdog_n = '0;
        if (berr_s && halt_s) nstate = S_ADDR;
      end
`endif
      default: nstate = S_IDLE;
    endcase
  end

  assign AS_     = !(state == S_ADDR || state == S_STRB || state == S_WAIT);
  assign DS_     = !(state == S_STRB || state == S_WAIT);
  assign RW_o    = (state == S_ADDR || state == S_STRB || state == S_WAIT ||
                    state == S_TERM) ? rw_q : 1'b1;
  assign A_lo    = off;
  assign SIZ     = siz_enc(off);
  assign lane_le = (state == S_TERM) ? lane_mask(off, bytes) : 4'b0000;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_cpu_term_seq.sv
// tb_cpu_term_seq: directed test of cpu_term_seq (default build) with
// hand-computed expectations; inputs change 1ns after the rising edge and
// outputs are sampled there.
module tb_cpu_term_seq;
  logic       BCLK = 1'b0;
  logic       CCRESET_;
  logic       start, rw;
  logic [7:0] len, tmo_limit;
  logic [1:0] DSACK_;
  logic       STERM_, BERR_;
  logic       AS_, DS_, RW_o, busy, done;
  logic [1:0] A_lo, SIZ, err;
  logic [3:0] lane_le;

  int n_cmp = 0;
  int n_mis = 0;

  cpu_term_seq dut (
    .BCLK(BCLK), .CCRESET_(CCRESET_), .start(start), .rw(rw), .len(len),
    .tmo_limit(tmo_limit), .DSACK_(DSACK_), .STERM_(STERM_), .BERR_(BERR_),
    .AS_(AS_), .DS_(DS_), .RW_o(RW_o), .A_lo(A_lo), .SIZ(SIZ),
    .lane_le(lane_le), .busy(busy), .done(done), .err(err));

  always #5 BCLK = ~BCLK;

  task automatic tick;
    @(posedge BCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] siz_exp [4];
    logic [3:0] lm;
    logic       found;
    siz_exp = '{2'b00, 2'b11, 2'b10, 2'b01};

    CCRESET_ = 1'b0; start = 1'b0; rw = 1'b1; len = 8'd0; tmo_limit = 8'd0;
    DSACK_ = 2'b11; STERM_ = 1'b1; BERR_ = 1'b1;
    #12;
    // reset state: {AS_,DS_,RW_o,busy,done}
    chk("rst_ctl", 32'({AS_, DS_, RW_o, busy, done}), 32'b11100);
    chk("rst_addr", 32'({A_lo, SIZ, err}), 0);
    chk("rst_lane", 32'(lane_le), 0);
    @(negedge BCLK); CCRESET_ = 1'b1;
    tick; tick;

    // 32-bit STERM_, read, len=2
    start = 1'b1; rw = 1'b1; len = 8'd2;
    tick; start = 1'b0;                                   // ADDR
    chk("st_addr_ctl", 32'({AS_, DS_, RW_o, busy}), 32'b0111);
    chk("st_addr_a", 32'({A_lo, SIZ}), 0);
    tick;                                                 // STRB
    chk("st_strb_ds", 32'(DS_), 0);
    tick; STERM_ = 1'b0;                                  // WAIT
    chk("st_wait_lane", 32'(lane_le), 0);
    tick; STERM_ = 1'b1;                                  // TERM
    chk("st_term1_lane", 32'(lane_le), 32'hF);
    chk("st_term1_strb", 32'({AS_, DS_}), 32'b11);
    tick;                                                 // ADDR
    chk("st_addr2", 32'({AS_, A_lo, SIZ}), 0);
    tick; tick; STERM_ = 1'b0;                            // WAIT
    tick; STERM_ = 1'b1;                                  // TERM
    chk("st_term2_lane", 32'(lane_le), 32'hF);
    tick;                                                 // DONE
    chk("st_done", 32'({done, err, AS_}), 32'b1001);
    tick;                                                 // IDLE
    chk("st_idle", 32'({done, busy}), 0);

    // 16-bit port, write, len=1
    start = 1'b1; rw = 1'b0; len = 8'd1;
    tick; start = 1'b0; DSACK_ = 2'b01;                   // ADDR
    chk("w16_addr1", 32'({RW_o, A_lo, SIZ}), 0);
    tick; tick; tick;                                     // TERM
    chk("w16_lane1", 32'(lane_le), 32'b0011);
    tick;                                                 // ADDR
    chk("w16_addr2", 32'({A_lo, SIZ}), 32'b1010);
    tick; tick; tick;                                     // TERM
    chk("w16_lane2", 32'(lane_le), 32'b1100);
    tick; DSACK_ = 2'b11;                                 // DONE
    chk("w16_done", 32'({done, err}), 32'b100);
    tick; tick; tick;

    // 8-bit port, read, len=1
    start = 1'b1; rw = 1'b1; len = 8'd1;
    tick; start = 1'b0; DSACK_ = 2'b10;                   // ADDR off=0
    for (int i = 0; i < 4; i++) begin
      chk("b8_addr", 32'({A_lo, SIZ}), 32'({i[1:0], siz_exp[i]}));
      tick; tick; tick;                                   // TERM
      lm = 4'b0001 << i;
      chk("b8_lane", 32'({done, lane_le}), 32'(lm));
      tick;
    end
    DSACK_ = 2'b11;                                       // DONE
    chk("b8_done", 32'({done, err}), 32'b100);
    tick;
    chk("b8_done_pulse", 32'(done), 0);
    tick; tick;

    // watchdog, limit 5; a start pulse mid-transfer is ignored
    tmo_limit = 8'd5; len = 8'd1;
    start = 1'b1;
    tick; start = 1'b0;                                   // ADDR
    tick; tick;                                           // WAIT1
    tick; start = 1'b1;                                   // WAIT2
    tick; start = 1'b0;                                   // WAIT3
    tick; tick;                                           // WAIT5
    chk("tmo_wait5", 32'({DS_, done}), 0);
    tick;                                                 // DONE
    chk("tmo_done", 32'({done, err, AS_, DS_}), 32'b11011);
    tick;
    chk("tmo_idle", 32'({busy, done}), 0);

    // watchdog disabled: waits until a 32-bit DSACK_ arrives
    tmo_limit = 8'd0;
    start = 1'b1;
    tick; start = 1'b0;
    repeat (40) tick;
    chk("tmo0_waiting", 32'({AS_, DS_, done}), 0);
    DSACK_ = 2'b00;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick;
      if (done) found = 1'b1;
    end
    chk("tmo0_done_seen", 32'(found), 1);
    chk("tmo0_err", 32'(err), 0);
    DSACK_ = 2'b11;
    tick; tick; tick;

    // BERR_ and STERM_ together in WAIT: bus error wins
    start = 1'b1;
    tick; start = 1'b0; BERR_ = 1'b0;                     // ADDR
    tick; tick; STERM_ = 1'b0;                            // WAIT
    chk("berr_wait_lane", 32'(lane_le), 0);
    tick; STERM_ = 1'b1; BERR_ = 1'b1;                    // DONE
    chk("berr_done", 32'({done, err, lane_le, AS_}), 32'b1_01_0000_1);
    tick; tick; tick;

    // zero length
    start = 1'b1; len = 8'd0;
    tick; start = 1'b0;                                   // DONE
    chk("zlen_done", 32'({done, err, AS_}), 32'b1111);
    tick;
    chk("zlen_idle", 32'({done, AS_}), 32'b01);

    // reset while in WAIT
    len = 8'd1;
    start = 1'b1;
    tick; start = 1'b0; tick; tick;                       // WAIT
    chk("rstmid_wait", 32'(AS_), 0);
    #2 CCRESET_ = 1'b0;
    #1;
    chk("rstmid_async", 32'({AS_, DS_, busy}), 32'b110);
    @(negedge BCLK); CCRESET_ = 1'b1;
    tick; tick;
    start = 1'b1;
    tick; start = 1'b0; tick; tick; STERM_ = 1'b0;        // WAIT
    tick; STERM_ = 1'b1;                                  // TERM
    chk("rstmid_lane", 32'(lane_le), 32'hF);
    tick;                                                 // DONE
    chk("rstmid_done", 32'({done, err}), 32'b100);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/cpu_term_seq.md
Name: cpu_term_seq

Overview:
- Parametrised successor to the single-flop CPU termination logic.
- Sequences complete 68030-style bus transfers of N longwords for the DMA master, one bus cycle at a time.
- Terminates each cycle on STERM_, DSACK_[1:0] (dynamic 8/16/32-bit sizing) or BERR_, and splits each longword into port-sized cycles.
- Sits between the DMA channel control and the CPU-side pad drivers.

Parameters:
- LEN_W, 8, width of the transfer length in longwords; maximum transfer is 2^LEN_W-1 longwords.
- SYNC_STAGES, 2, synchroniser depth on DSACK_ and BERR_ (1..3); STERM_ is never synchronised.
- TMO_W, 8, width of the watchdog counter.

Ports:
- BCLK  in  1  system clock; all state updates on rising edge.
- CCRESET_  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- rw  in  1  1=read, 0=write; latched at start.
- len  in  LEN_W  longword count, latched at start.
- tmo_limit  in  TMO_W  watchdog limit in BCLK cycles; 0 disables the watchdog.
- DSACK_  in  2  async data-strobe acknowledge, active low.
- STERM_  in  1  synchronous 32-bit termination, active low.
- BERR_  in  1  async bus error, active low.
- AS_  out  1  address strobe, active low.
- DS_  out  1  data strobe, active low.
- RW_o  out  1  bus direction.
- A_lo  out  2  A[1:0] byte offset within the current longword.
- SIZ  out  2  68030 SIZ encoding of remaining bytes: 4=00, 1=01, 2=10, 3=11.
- lane_le  out  4  per-byte latch/drive enable, one-cycle pulse at termination.
- busy  out  1  high from start acceptance until the DONE state exits.
- done  out  1  one-cycle pulse at completion.
- err  out  2  completion status, valid with done: 00 ok, 01 bus error, 10 timeout, 11 zero length.

Behaviour:
- Reset values: AS_=1, DS_=1, RW_o=1, A_lo=0, SIZ=00, lane_le=0, busy=0, done=0, err=00, state=IDLE; counters cleared.
- Reset asserted mid-cycle releases the strobes asynchronously in the same instant.
- States: IDLE, ADDR, STRB, WAIT, TERM, DONE.

State transitions:
- IDLE: on start with len=0, go to DONE with err=11 and no bus cycle.
- IDLE: on start with len!=0, latch rw and len, set off=0 and rem=len, go to ADDR; busy rises in the next cycle.
- ADDR: drive A_lo=off and SIZ=(4-off) mod 4; AS_=0. Go to STRB.
- STRB: DS_=0; go to WAIT.
- WAIT: sample terminations each cycle. Priority is BERR_ (synchronised) > STERM_ (raw) > DSACK_ (synchronised).
  - BERR_: go to DONE with err=01.
  - STERM_=0 or DSACK_=00: port width 4.
  - DSACK_=01: port width 2.
  - DSACK_=10: port width 1.
  - DSACK_=11: keep waiting and increment the watchdog. When the watchdog reaches tmo_limit (nonzero), go to DONE with err=10.
- TERM: the watchdog clears.
  - bytes = min(port - (off mod port), 4 - off).
  - Pulse lane_le for lanes off..off+bytes-1.
  - Negate AS_ and DS_; off += bytes.
  - If off=4: clear off and decrement rem.
  - Next state is ADDR if rem!=0 or off!=0, otherwise DONE.
- DONE: strobes are negated, done pulses for exactly one cycle, busy falls, and the state returns to IDLE in the next cycle.

Rules and boundary cases:
- Strobes are always negated for at least one cycle (TERM) between bus cycles.
- start outside IDLE is ignored.
- A termination arriving in the same cycle as the watchdog limit is honoured as a termination, not a timeout.
- DSACK_ still asserted on the first WAIT cycle after TERM is treated as a fresh termination. This is legal: DSACK negation is the slave's responsibility.
- rem arithmetic is unsigned LEN_W; it never underflows because the decrement happens only with rem!=0.

Optional Feature:
- Macro: CPU_TERM_RETRY_EN.
- Enabled: simultaneous BERR_ and HALT (an extra 1-bit port halt_, active low, synchronised like BERR_) is a retry.
  - Negate the strobes and wait in a RETRY state until both negate, then re-run the same bus cycle (same off and rem).
  - At most 3 retries per cycle; the fourth gives err=01.
- Disabled: no halt_ port and no RETRY state; BERR_ always terminates with err=01.

Decomposition:
- Shared package cpu_term_pkg:
  - state enum;
  - err code constants (ERR_OK, ERR_BERR, ERR_TMO, ERR_ZLEN);
  - SIZ encoding constants;
  - the port-width decode function from DSACK_/STERM_ to 1/2/4.
- One sub-module, cpu_sync: an SYNC_STAGES-deep synchroniser vector reset to all-ones (negated) on CCRESET_. It is instantiated for DSACK_ and BERR_ (and halt_ when enabled).

Test Plan:
- 32-bit STERM_: len=2, read, STERM_ low for 1 cycle on each WAIT -> 2 bus cycles, lane_le=1111 twice, A_lo=00, SIZ=00, done with err=00.
- 16-bit port: len=1, DSACK_=01 -> 2 cycles: A_lo=00 SIZ=00 lane_le=0011, then A_lo=10 SIZ=10 lane_le=1100; err=00.
- 8-bit port: len=1, DSACK_=10 -> 4 cycles with A_lo 0,1,2,3, SIZ 00,11,10,01 and one-hot lane_le; done pulses once.
- Watchdog: tmo_limit=5, DSACK_=11 held -> DONE after 5 WAIT cycles, err=10, strobes negated; tmo_limit=0 -> waits indefinitely.
- Bus error priority: BERR_ and STERM_ both low in the same cycle -> err=01, lane_le stays 0; len=0 start -> done on the next cycle with err=11 and AS_ never low.
- Reset mid-transfer: CCRESET_ low while in WAIT -> AS_ and DS_ high immediately, busy=0; a new start afterwards completes normally.
